// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous single-port RAM between a CPU port and a
// loader/debug port. The CPU normally wins, but a pending loader request may
// only lose STARVE_LIMIT consecutive cycles. The loader can also take
// exclusive ownership (hold_req/held), which freezes the CPU.
//
// Ports
//   clk, reset_n                         clock, synchronous active-low reset
//   cpu_req/we/addr/wdata                CPU access request
//   cpu_stall                            CPU request not granted this cycle
//   cpu_rvalid, cpu_rdata                CPU read completion (1 cycle after grant)
//   ldr_req/we/addr/wdata                loader request, held until ldr_ack
//   ldr_ack, ldr_rdata                   loader completion pulse and read data
//   hold_req, held                       exclusive ownership request / grant
//   mem_en/we/addr/wdata, mem_rdata      RAM port (read data one cycle late)
//
// State table
//   state | meaning
//   RUN   | shared operation, CPU favoured with starvation guard
//   DRAIN | hold requested; CPU excluded, last RUN access completing
//   HELD  | loader owns the RAM exclusively, held=1

module mem_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_stall,
  output logic       cpu_rvalid,
  output logic [7:0] cpu_rdata,
  input  logic       ldr_req,
  input  logic       ldr_we,
  input  logic [7:0] ldr_addr,
  input  logic [7:0] ldr_wdata,
  output logic       ldr_ack,
  output logic [7:0] ldr_rdata,
  input  logic       hold_req,
  output logic       held,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HELD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_LDR  = 2'd2
  } owner_t;

  state_t     state_q, state_d;
  owner_t     owner_q, owner_d;
  logic       own_we_q, own_we_d;
  logic [3:0] starve_q, starve_d;
  logic       held_q, held_d;

  logic       cpu_gnt;
  logic       ldr_gnt;
  logic       ldr_elig;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      owner_q  <= OWN_NONE;
      own_we_q <= 1'b0;
      starve_q <= 4'd0;
      held_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      own_we_q <= own_we_d;
      starve_q <= starve_d;
      held_q   <= held_d;
    end
  end

  // Completions are masked while reset is low so an access granted just
  // before reset never reports completion.
  assign ldr_ack    = reset_n && (owner_q == OWN_LDR);
  assign cpu_rvalid = reset_n && (owner_q == OWN_CPU) && !own_we_q;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 8'd0;
  assign ldr_rdata  = (ldr_ack && !own_we_q) ? mem_rdata : 8'd0;
  assign held       = held_q;

  // The request is still high in its ack cycle; ignoring it there prevents a
  // second service of the same access.
  assign ldr_elig = ldr_req && !ldr_ack;

  always_comb begin
    cpu_gnt = 1'b0;
    ldr_gnt = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        ST_RUN: begin
          if (ldr_elig && (!cpu_req || starve_q == LIMIT)) begin
            ldr_gnt = 1'b1;
          end else if (cpu_req) begin
            cpu_gnt = 1'b1;
          end
        end
        ST_DRAIN, ST_HELD: begin
          ldr_gnt = ldr_elig;
        end
        default: begin
          cpu_gnt = 1'b0;
          ldr_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (hold_req) state_d = ST_DRAIN;
      ST_DRAIN: state_d = hold_req ? ST_HELD : ST_RUN;
      ST_HELD:  if (!hold_req) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    held_d = (state_d == ST_HELD);
  end

  always_comb begin
    starve_d = starve_q;
    if (state_q != ST_RUN || !ldr_req || ldr_gnt) begin
      starve_d = 4'd0;
    end else if (ldr_elig && starve_q != LIMIT) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    owner_d  = OWN_NONE;
    own_we_d = 1'b0;
    if (cpu_gnt) begin
      owner_d  = OWN_CPU;
      own_we_d = cpu_we;
    end else if (ldr_gnt) begin
      owner_d  = OWN_LDR;
      own_we_d = ldr_we;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ldr_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ldr_we;
      mem_addr  = ldr_addr;
      mem_wdata = ldr_wdata;
    end
  end

  assign cpu_stall = cpu_req && !cpu_gnt;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, range 1..15: maximum consecutive cycles a pending loader request loses to the CPU.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 cpu_req  input  1  CPU requests a RAM access this cycle.
REQ-005 cpu_we  input  1  CPU access is a write.
REQ-006 cpu_addr  input  8  CPU address.
REQ-007 cpu_wdata  input  8  CPU write data.
REQ-008 cpu_stall  output  1  CPU request not granted this cycle; CPU holds its request and its state.
REQ-009 cpu_rvalid  output  1  cpu_rdata is valid (the cycle after a granted CPU read).
REQ-010 cpu_rdata  output  8  CPU read data.
REQ-011 ldr_req  input  1  loader/debug port request; held high until ldr_ack.
REQ-012 ldr_we, ldr_addr, ldr_wdata  input  1/8/8  loader access type, address and write data.
REQ-013 ldr_ack  output  1  one-cycle pulse: loader access completed; ldr_rdata is valid for reads.
REQ-014 ldr_rdata  output  8  loader read data.
REQ-015 hold_req  input  1  loader requests exclusive RAM ownership (CPU frozen).
REQ-016 held  output  1  exclusive ownership granted; no CPU access is in flight.
REQ-017 mem_en, mem_we  output  1/1  RAM access enable and write enable.
REQ-018 mem_addr, mem_wdata  output  8/8  RAM address and write data.
REQ-019 mem_rdata  input  8  RAM read data; synchronous, valid one cycle after mem_en with mem_we=0.

Function
REQ-020 At most one requester SHALL be granted per cycle; the granted requester's we/addr/wdata SHALL drive mem_we/mem_addr/mem_wdata combinationally with mem_en=1; with no grant, mem_en=0, mem_we=0 and mem_addr/mem_wdata=0.
REQ-021 State machine states: RUN, DRAIN, HELD.
REQ-022 RUN: CPU SHALL win when both request, except that the loader SHALL win when the starve counter equals STARVE_LIMIT.
REQ-023 RUN->DRAIN when hold_req=1; DRAIN->HELD on the next cycle if hold_req=1; DRAIN->RUN if hold_req=0; HELD->RUN when hold_req=0.
REQ-024 In DRAIN and HELD the CPU SHALL never be granted; the loader is granted whenever eligible.
REQ-025 The loader SHALL be ineligible in the cycle ldr_ack=1, so a held ldr_req is never serviced twice.
REQ-026 Starve counter, 4 bits, saturating at STARVE_LIMIT: +1 per RUN cycle in which the loader is eligible and not granted; cleared when the loader is granted, when ldr_req=0, or outside RUN.
REQ-027 cpu_stall = cpu_req AND NOT CPU granted, combinational.
REQ-028 A registered owner (NONE/CPU/LDR) SHALL record the cycle's grant and access type; the next cycle, a CPU read gives cpu_rvalid=1 with cpu_rdata=mem_rdata, and any loader grant gives ldr_ack=1 with ldr_rdata=mem_rdata for reads.
REQ-029 cpu_rdata/ldr_rdata SHALL be 0 when not valid; cpu_rvalid SHALL be 0 after CPU writes.
REQ-030 held = 1 exactly when state is HELD, registered.
REQ-031 Latency: a granted access completes one cycle after its grant; an unstalled CPU read has 1-cycle latency.
REQ-032 Simultaneous hold_req rise and CPU-favoured arbitration: the RUN cycle's grant stands; the CPU is excluded from the following cycle.

Reset
REQ-033 While reset_n=0 at a rising edge: state<=RUN, owner<=NONE, counter<=0, ldr_ack<=0, cpu_rvalid<=0, held<=0.
REQ-034 While reset_n=0, no grant SHALL be issued: mem_en=0 and cpu_stall=cpu_req.
REQ-035 Reset asserted mid-access SHALL discard the in-flight completion: no ldr_ack or cpu_rvalid in the cycle after reset.

Verification
REQ-036 CPU read addr 0x10, RAM[0x10]=0xA5, no loader -> mem_en=1 and mem_addr=0x10 in cycle N; cpu_rvalid=1 and cpu_rdata=0xA5 in N+1; cpu_stall=0 throughout.
REQ-037 cpu_req held high, ldr_req held high, STARVE_LIMIT=3 -> CPU granted 3 cycles, then the loader is granted once (cpu_stall=1 that cycle), ldr_ack the next cycle, then the CPU resumes.
REQ-038 hold_req=1 with CPU streaming -> DRAIN for 1 cycle, held=1 from the second cycle, cpu_stall=1 throughout; loader writes 0x3C to 0x80 and acks; hold_req=0 -> RUN, CPU granted the next cycle.
REQ-039 ldr_req held high across its ack for two back-to-back writes -> exactly one ldr_ack per access, one idle loader cycle between grants, and no duplicate mem_we for the first access.
REQ-040 Reset asserted the cycle after a loader read grant -> no ldr_ack, owner NONE, counter 0, mem_en=0 during reset.
REQ-041 hold_req pulsed for 1 cycle (RUN->DRAIN->RUN) -> held never asserts, and the CPU is stalled for exactly one cycle.
